// File: rtl/ocl_lite_master_if.sv
// Command/response port plus AXI4-Lite AW/W/B/AR/R channels of ocl_lite_master.
// Latency: none, this is wiring only.
// Backpressure: cmd/rsp use valid/ready; each AXI channel uses its own valid/ready pair.
interface ocl_lite_master_if #(
    parameter int ADDR_W = 32
);
    // Command from the requester
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [31:0]       cmd_wdata;
    logic [3:0]        cmd_wstrb;

    // Response back to the requester
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic [1:0]        rsp_resp;
    logic              rsp_timeout;

    // Write address channel
    logic              awvalid;
    logic [ADDR_W-1:0] awaddr;
    logic              awready;

    // Write data channel
    logic              wvalid;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wready;

    // Write response channel
    logic              bvalid;
    logic [1:0]        bresp;
    logic              bready;

    // Read address channel
    logic              arvalid;
    logic [ADDR_W-1:0] araddr;
    logic              arready;

    // Read data channel
    logic              rvalid;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rready;

    // View from the initiator
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
        input  rsp_ready,
        output awvalid, awaddr,
        input  awready,
        output wvalid, wdata, wstrb,
        input  wready,
        input  bvalid, bresp,
        output bready,
        output arvalid, araddr,
        input  arready,
        input  rvalid, rdata, rresp,
        output rready
    );

    // View from the requester and the register slave together
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
        output rsp_ready,
        input  awvalid, awaddr,
        output awready,
        input  wvalid, wdata, wstrb,
        output wready,
        output bvalid, bresp,
        input  bready,
        input  arvalid, araddr,
        output arready,
        output rvalid, rdata, rresp,
        input  rready
    );
endinterface

// File: rtl/ocl_lite_master.sv
// AXI4-Lite initiator: one outstanding single-beat write or read, with a response watchdog.
// Latency: rsp_valid 3 cycles after the command handshake when the slave never stalls.
// Backpressure: cmd_ready only in IDLE; rsp held until rsp_ready; watchdog forces a SLVERR response.
module ocl_lite_master #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                clk_main_a0,
    input  logic                rst_main,
    ocl_lite_master_if.master   bus
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RSP
    } state_t;

    // Watchdog sizing: the counter saturates at TIMEOUT_CYCLES, so it never wraps
    // even after a handshake wins in the expiry cycle and the count runs on.
    localparam bit             WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam int             WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_EN ? WD_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);

    state_t          state_q;
    state_t          state_d;
    logic            aw_done_q;
    logic            aw_done_d;
    logic            w_done_q;
    logic            w_done_d;
    logic [WD_W-1:0] wd_cnt_q;
    logic [WD_W-1:0] wd_cnt_d;
    logic [WD_W-1:0] wd_cnt_inc;
    logic            wd_expire;
    logic            timeout_d;

    logic            cmd_fire;
    logic            rsp_fire;
    logic            aw_fire;
    logic            w_fire;
    logic            b_fire;
    logic            ar_fire;
    logic            r_fire;

    // Handshakes are formed from registered valid/ready outputs, so no input reaches an output combinationally.
    assign cmd_fire = bus.cmd_valid & bus.cmd_ready;
    assign rsp_fire = bus.rsp_valid & bus.rsp_ready;
    assign aw_fire  = bus.awvalid   & bus.awready;
    assign w_fire   = bus.wvalid    & bus.wready;
    assign b_fire   = bus.bvalid    & bus.bready;
    assign ar_fire  = bus.arvalid   & bus.arready;
    assign r_fire   = bus.rvalid    & bus.rready;

    assign wd_cnt_inc = (wd_cnt_q == WD_MAX) ? wd_cnt_q : wd_cnt_q + 1'b1;
    assign wd_expire  = WD_EN && (wd_cnt_q >= WD_LAST);

    // Next-state, beat-tracking and watchdog logic; a completing handshake always beats the watchdog.
    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        wd_cnt_d  = wd_cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    wd_cnt_d = '0;
                    state_d  = bus.cmd_write ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                wd_cnt_d = wd_cnt_inc;
                if ((aw_done_q | aw_fire) && (w_done_q | w_fire)) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WR_RESP;
                end else if (wd_expire) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = RSP;
                end else begin
                    aw_done_d = aw_done_q | aw_fire;
                    w_done_d  = w_done_q | w_fire;
                end
            end
            WR_RESP: begin
                wd_cnt_d = wd_cnt_inc;
                if (b_fire) begin
                    state_d = RSP;
                end else if (wd_expire) begin
                    timeout_d = 1'b1;
                    state_d   = RSP;
                end
            end
            RD_REQ: begin
                wd_cnt_d = wd_cnt_inc;
                if (ar_fire) begin
                    state_d = RD_RESP;
                end else if (wd_expire) begin
                    timeout_d = 1'b1;
                    state_d   = RSP;
                end
            end
            RD_RESP: begin
                wd_cnt_d = wd_cnt_inc;
                if (r_fire) begin
                    state_d = RSP;
                end else if (wd_expire) begin
                    timeout_d = 1'b1;
                    state_d   = RSP;
                end
            end
            RSP: begin
                if (rsp_fire) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, write-beat flags and watchdog counter.
    always_ff @(posedge clk_main_a0 or posedge rst_main) begin
        if (rst_main) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            wd_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            wd_cnt_q  <= wd_cnt_d;
        end
    end

    // Valid/ready outputs registered from the next state so each appears exactly with its state.
    always_ff @(posedge clk_main_a0 or posedge rst_main) begin
        if (rst_main) begin
            bus.cmd_ready <= 1'b1;
            bus.awvalid   <= 1'b0;
            bus.wvalid    <= 1'b0;
            bus.bready    <= 1'b0;
            bus.arvalid   <= 1'b0;
            bus.rready    <= 1'b0;
            bus.rsp_valid <= 1'b0;
        end else begin
            bus.cmd_ready <= (state_d == IDLE);
            bus.awvalid   <= (state_d == WR_REQ) && !aw_done_d;
            bus.wvalid    <= (state_d == WR_REQ) && !w_done_d;
            bus.bready    <= (state_d == WR_RESP);
            bus.arvalid   <= (state_d == RD_REQ);
            bus.rready    <= (state_d == RD_RESP);
            bus.rsp_valid <= (state_d == RSP);
        end
    end

    // Channel payload captured at command acceptance and held stable until the next command.
    always_ff @(posedge clk_main_a0 or posedge rst_main) begin
        if (rst_main) begin
            bus.awaddr <= {ADDR_W{1'b0}};
            bus.araddr <= {ADDR_W{1'b0}};
            bus.wdata  <= 32'h0;
            bus.wstrb  <= 4'h0;
        end else if (cmd_fire) begin
            if (bus.cmd_write) begin
                bus.awaddr <= bus.cmd_addr;
                bus.wdata  <= bus.cmd_wdata;
                bus.wstrb  <= bus.cmd_wstrb;
            end else begin
                bus.araddr <= bus.cmd_addr;
            end
        end
    end

    // Response fields: slave response, or SLVERR with zero data when the watchdog fires.
    always_ff @(posedge clk_main_a0 or posedge rst_main) begin
        if (rst_main) begin
            bus.rsp_rdata   <= 32'h0;
            bus.rsp_resp    <= 2'b00;
            bus.rsp_timeout <= 1'b0;
        end else if (timeout_d) begin
            bus.rsp_rdata   <= 32'h0;
            bus.rsp_resp    <= 2'b10;
            bus.rsp_timeout <= 1'b1;
        end else if ((state_q == WR_RESP) && b_fire) begin
            bus.rsp_rdata   <= 32'h0;
            bus.rsp_resp    <= bus.bresp;
            bus.rsp_timeout <= 1'b0;
        end else if ((state_q == RD_RESP) && r_fire) begin
            bus.rsp_rdata   <= bus.rdata;
            bus.rsp_resp    <= bus.rresp;
            bus.rsp_timeout <= 1'b0;
        end else if (rsp_fire) begin
            bus.rsp_timeout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ocl_lite_master.sv
// Directed bench for ocl_lite_master with TIMEOUT_CYCLES = 16.
// Table vectors drive a cycle-scheduled slave; hand sequences cover late responses and reset.
// Cycle 0 is the command handshake; cycle n is the n-th cycle after it.
module tb_ocl_lite_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ocl_lite_master_if #(.ADDR_W(32)) bus ();

    ocl_lite_master #(.ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
        .clk_main_a0 (clk),
        .rst_main    (rst),
        .bus         (bus.master)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] s_rdata;   // data the slave returns
        logic [1:0]  s_resp;    // BRESP/RRESP the slave returns
        int          aw_at;     // first cycle awready is high
        int          w_at;
        int          b_at;      // earliest cycle bvalid may rise
        int          ar_at;
        int          r_at;
        int          hold;      // cycles rsp_ready is held low
        int          e_cyc;     // expected first rsp_valid cycle
        logic [31:0] e_rdata;
        logic [1:0]  e_resp;
        logic        e_to;
        int          e_aw_cyc;  // cycles awvalid is high
        int          e_w_cyc;
        int          e_ar_cyc;
        int          e_aw_n;    // handshakes per channel
        int          e_w_n;
        int          e_ar_n;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] ctl_word();
        return {bus.cmd_ready, bus.rsp_valid, bus.awvalid, bus.wvalid, bus.bready,
                bus.arvalid, bus.rready, bus.rsp_timeout, bus.rsp_resp};
    endfunction

    task automatic slave_idle();
        bus.awready = 1'b0; bus.wready = 1'b0;
        bus.bvalid = 1'b0; bus.bresp = 2'b00;
        bus.arready = 1'b0;
        bus.rvalid = 1'b0; bus.rdata = 32'h0; bus.rresp = 2'b00;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " ctl"}, {22'h0, ctl_word()}, 32'h200);
        chk({tag, " awaddr"}, bus.awaddr, 32'h0);
        chk({tag, " araddr"}, bus.araddr, 32'h0);
        chk({tag, " wdata"}, bus.wdata, 32'h0);
        chk({tag, " wstrb_rdata"}, {28'h0, bus.wstrb} | bus.rsp_rdata, 32'h0);
    endtask

    task automatic send_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wd;
        bus.cmd_wstrb = ws;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int  cyc = 1;
        int  aw_n = 0, w_n = 0, ar_n = 0;
        int  aw_c = 0, w_c = 0, ar_c = 0;
        bit  b_done = 0, r_done = 0;
        bit  proto_bad = 0, pay_bad = 0, hold_bad = 0;
        int  rsp_cyc;
        string p;
        p = $sformatf("v%0d", idx);
        chk({p, " cmd_ready_before"}, {31'h0, bus.cmd_ready}, 32'h1);
        send_cmd(v.wr, v.addr, v.wdata, v.wstrb);
        while (!bus.rsp_valid && cyc <= 40) begin
            if (bus.cmd_ready) proto_bad = 1;
            if (bus.bready && !(aw_n > 0 && w_n > 0)) proto_bad = 1;
            if (bus.rready && ar_n == 0) proto_bad = 1;
            if (bus.awvalid && bus.awaddr !== v.addr) pay_bad = 1;
            if (bus.wvalid && {bus.wdata, bus.wstrb} !== {v.wdata, v.wstrb}) pay_bad = 1;
            if (bus.arvalid && bus.araddr !== v.addr) pay_bad = 1;
            if (bus.awvalid) aw_c++;
            if (bus.wvalid) w_c++;
            if (bus.arvalid) ar_c++;
            bus.awready = (cyc >= v.aw_at);
            bus.wready  = (cyc >= v.w_at);
            bus.arready = (cyc >= v.ar_at);
            bus.bvalid  = (aw_n > 0) && (w_n > 0) && !b_done && (cyc >= v.b_at);
            bus.bresp   = bus.bvalid ? v.s_resp : 2'b00;
            bus.rvalid  = (ar_n > 0) && !r_done && (cyc >= v.r_at);
            bus.rdata   = bus.rvalid ? v.s_rdata : 32'h0;
            bus.rresp   = bus.rvalid ? v.s_resp : 2'b00;
            if (bus.awvalid && bus.awready) aw_n++;
            if (bus.wvalid && bus.wready) w_n++;
            if (bus.arvalid && bus.arready) ar_n++;
            if (bus.bvalid && bus.bready) b_done = 1;
            if (bus.rvalid && bus.rready) r_done = 1;
            tick();
            cyc++;
        end
        slave_idle();
        rsp_cyc = bus.rsp_valid ? cyc : -1;
        chk({p, " rsp_cycle"}, rsp_cyc, v.e_cyc);
        chk({p, " rsp_rdata"}, bus.rsp_rdata, v.e_rdata);
        chk({p, " rsp_resp"}, {30'h0, bus.rsp_resp}, {30'h0, v.e_resp});
        chk({p, " rsp_timeout"}, {31'h0, bus.rsp_timeout}, {31'h0, v.e_to});
        chk({p, " aw_valid_cycles"}, aw_c, v.e_aw_cyc);
        chk({p, " w_valid_cycles"}, w_c, v.e_w_cyc);
        chk({p, " ar_valid_cycles"}, ar_c, v.e_ar_cyc);
        chk({p, " beats_aw_w_ar"}, {aw_n[7:0], w_n[7:0], ar_n[7:0]}, {v.e_aw_n[7:0], v.e_w_n[7:0], v.e_ar_n[7:0]});
        chk({p, " protocol"}, {31'h0, proto_bad}, 32'h0);
        chk({p, " payload"}, {31'h0, pay_bad}, 32'h0);
        for (int k = 0; k < v.hold; k++) begin
            tick();
            if (!bus.rsp_valid || bus.cmd_ready || bus.rsp_rdata !== v.e_rdata ||
                bus.rsp_resp !== v.e_resp || bus.rsp_timeout !== v.e_to) hold_bad = 1;
        end
        chk({p, " rsp_hold_stable"}, {31'h0, hold_bad}, 32'h0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk({p, " after_rsp {cmd_ready,rsp_valid,timeout}"},
            {29'h0, bus.cmd_ready, bus.rsp_valid, bus.rsp_timeout}, 32'h4);
    endtask

    initial begin
        // wr addr wdata wstrb s_rdata s_resp | aw w b ar r hold | e_cyc e_rdata e_resp e_to | aw_c w_c ar_c aw_n w_n ar_n
        vecs[0] = '{1'b1, 32'h500, 32'h12345678, 4'hF, 32'h0, 2'b00, 1, 1, 2, 0, 0, 0,
                    3, 32'h0, 2'b00, 1'b0, 1, 1, 0, 1, 1, 0};
        vecs[1] = '{1'b1, 32'h508, 32'hA5A50001, 4'h3, 32'h0, 2'b00, 4, 1, 0, 0, 0, 2,
                    6, 32'h0, 2'b00, 1'b0, 4, 1, 0, 1, 1, 0};
        vecs[2] = '{1'b1, 32'h50C, 32'hFFFF0000, 4'hC, 32'h0, 2'b10, 1, 3, 7, 0, 0, 0,
                    8, 32'h0, 2'b10, 1'b0, 1, 3, 0, 1, 1, 0};
        vecs[3] = '{1'b0, 32'h504, 32'h0, 4'h0, 32'h0000BEEF, 2'b00, 0, 0, 0, 1, 7, 10,
                    8, 32'h0000BEEF, 2'b00, 1'b0, 0, 0, 1, 0, 0, 1};
        vecs[4] = '{1'b0, 32'h600, 32'h0, 4'h0, 32'hCAFEF00D, 2'b11, 0, 0, 0, 3, 0, 1,
                    5, 32'hCAFEF00D, 2'b11, 1'b0, 0, 0, 3, 0, 0, 1};
        vecs[5] = '{1'b0, 32'h700, 32'h0, 4'h0, 32'hDEADDEAD, 2'b00, 0, 0, 0, 99, 0, 0,
                    17, 32'h0, 2'b10, 1'b1, 0, 0, 16, 0, 0, 0};
        vecs[6] = '{1'b1, 32'h710, 32'h55AA55AA, 4'hF, 32'h0, 2'b00, 1, 1, 99, 0, 0, 3,
                    17, 32'h0, 2'b10, 1'b1, 1, 1, 0, 1, 1, 0};
        vecs[7] = '{1'b1, 32'h720, 32'h0BADCAFE, 4'h1, 32'h0, 2'b01, 16, 1, 0, 0, 0, 0,
                    18, 32'h0, 2'b01, 1'b0, 16, 1, 0, 1, 1, 0};
        vecs[8] = '{1'b0, 32'h730, 32'h0, 4'h0, 32'h13579BDF, 2'b00, 0, 0, 0, 16, 0, 0,
                    18, 32'h13579BDF, 2'b00, 1'b0, 0, 0, 16, 0, 0, 1};
        vecs[9] = '{1'b0, 32'h734, 32'h0, 4'h0, 32'h77777777, 2'b00, 0, 0, 0, 1, 99, 0,
                    17, 32'h0, 2'b10, 1'b1, 0, 0, 1, 0, 0, 1};

        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h0;
        bus.cmd_wdata = 32'h0; bus.cmd_wstrb = 4'h0; bus.rsp_ready = 1'b0;
        slave_idle();

        tick();
        tick();
        check_reset_values("reset");
        rst = 1'b0;
        tick();
        check_reset_values("post_reset_idle");

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Timed-out read, then a late rvalid from the slave must be ignored.
        begin
            int  n = 0;
            bit  late_bad = 0;
            send_cmd(1'b0, 32'h740, 32'h0, 4'h0);
            while (!bus.rsp_valid && n < 30) begin
                tick();
                n++;
            end
            chk("late_r rsp_after_timeout", {31'h0, bus.rsp_valid}, 32'h1);
            bus.rvalid = 1'b1; bus.rdata = 32'h11112222; bus.rresp = 2'b00;
            for (int k = 0; k < 3; k++) begin
                tick();
                if (bus.rready || bus.rsp_rdata !== 32'h0 || !bus.rsp_timeout || bus.rsp_resp !== 2'b10) late_bad = 1;
            end
            bus.rsp_ready = 1'b1;
            tick();
            bus.rsp_ready = 1'b0;
            if (bus.rready || !bus.cmd_ready || bus.rsp_valid) late_bad = 1;
            tick();
            if (bus.rready || !bus.cmd_ready || bus.rsp_valid) late_bad = 1;
            chk("late_r ignored", {31'h0, late_bad}, 32'h0);
            slave_idle();
            run_vec(vecs[3], 13);
        end

        // Reset asserted while waiting in WR_RESP: abandoned, no response.
        begin
            bit rst_bad = 0;
            send_cmd(1'b1, 32'h800, 32'hFEEDFACE, 4'hF);
            bus.awready = 1'b1; bus.wready = 1'b1;
            tick();
            bus.awready = 1'b0; bus.wready = 1'b0;
            chk("rst_wr bready_in_wr_resp", {31'h0, bus.bready}, 32'h1);
            chk("rst_wr awaddr_loaded", bus.awaddr, 32'h800);
            rst = 1'b1;
            #1;
            check_reset_values("rst_wr immediate");
            bus.bvalid = 1'b1; bus.bresp = 2'b00;
            tick();
            tick();
            rst = 1'b0;
            for (int k = 0; k < 5; k++) begin
                tick();
                if (bus.rsp_valid || !bus.cmd_ready || bus.bready) rst_bad = 1;
            end
            slave_idle();
            chk("rst_wr no_response", {31'h0, rst_bad}, 32'h0);
            run_vec(vecs[0], 20);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
